// File: rtl/axis_ball_pkg.sv
// Shared constants, FSM state type and pixel-window helper for the ball centroid tracker.
package axis_ball_pkg;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam logic [15:0] OVERLAY_RGB = 16'hF800;

  localparam int CENTROID_COORD_W = 12;
  localparam int CENTROID_CNT_W   = 20;
  localparam int CENTROID_ACC_W   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_e;

  // Inclusive window test; a window with lo > hi can never match.
  function automatic logic in_window(input logic [5:0] v, input logic [5:0] lo, input logic [5:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/axis_ball_centroid_if.sv
// AXI4-Stream video beat bundle (RGB565) shared by the input and output sides.
interface axis_ball_centroid_if;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;
  logic [1:0]  tkeep;

  modport master (output tdata, tvalid, tuser, tlast, tkeep, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_ball_centroid_divider.sv
// Restoring divider producing a QUOT_W-bit quotient, one bit per clock, MSB first.
module seq_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 20,
  parameter int QUOT_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  localparam int DW = (DIVIDEND_W > DIVISOR_W + QUOT_W) ? DIVIDEND_W : DIVISOR_W + QUOT_W;
  localparam int IW = $clog2(QUOT_W + 1);

  logic [DW-1:0]     rem_r;
  logic [DW-1:0]     den_r;
  logic [DW-1:0]     diff_s;
  logic              ge_s;
  logic [QUOT_W-1:0] quot_r;
  logic [IW-1:0]     iter_r;
  logic              busy_r;
  logic              done_r;

  // Trial subtraction of the shifted divisor against the running remainder.
  always_comb begin
    ge_s   = (rem_r >= den_r);
    diff_s = rem_r - den_r;
  end

  // Iteration state; the quotient is valid from the done pulse until the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r  <= '0;
      den_r  <= '0;
      quot_r <= '0;
      iter_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start && !busy_r) begin
        rem_r  <= DW'(dividend);
        den_r  <= DW'(divisor) << (QUOT_W - 1);
        quot_r <= '0;
        iter_r <= IW'(QUOT_W);
        busy_r <= 1'b1;
      end else if (busy_r) begin
        if (ge_s) begin
          rem_r <= diff_s;
        end
        quot_r <= {quot_r[QUOT_W-2:0], ge_s};
        den_r  <= den_r >> 1;
        iter_r <= iter_r - IW'(1);
        if (iter_r == IW'(1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign quotient = quot_r;

endmodule

// File: rtl/axis_ball_centroid.sv
// Zero-latency RGB565 pass-through that thresholds pixels, accumulates ball coordinates
// per frame and reports the centroid through two parallel sequential dividers.
module axis_ball_centroid
  import axis_ball_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COORD_W    = CENTROID_COORD_W,
  parameter int CNT_W      = CENTROID_CNT_W,
  parameter int ACC_W      = CENTROID_ACC_W,
  parameter int MIN_PIXELS = 16
) (
  input  logic                 s_axis_video_aclk,
  input  logic                 s_axis_video_aresetn,
  axis_ball_centroid_if.slave  s_axis_video,
  axis_ball_centroid_if.master m_axis_video,
  input  logic [4:0]           r_lo,
  input  logic [4:0]           r_hi,
  input  logic [5:0]           g_lo,
  input  logic [5:0]           g_hi,
  input  logic [4:0]           b_lo,
  input  logic [4:0]           b_hi,
  input  logic                 overlay_en,
  output logic [COORD_W-1:0]   ball_x,
  output logic [COORD_W-1:0]   ball_y,
  output logic                 ball_found,
  output logic [CNT_W-1:0]     pixel_count,
  output logic                 result_valid,
  output logic [15:0]          frame_err_cnt
);

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_PIXELS);

  logic               beat_s, mask_s, frame_end_s, sof_err_s;
  logic [COORD_W-1:0] x_r, y_r, x_beat_s, y_beat_s;
  logic [ACC_W-1:0]   sum_x_r, sum_y_r, base_sx_s, base_sy_s, sum_x_nxt_s, sum_y_nxt_s;
  logic [CNT_W-1:0]   cnt_r, base_cnt_s, cnt_nxt_s, cnt_lat_r;
  logic               active_r, small_pend_r;
  state_e             state_r, state_nxt_s;
  logic               div_start_s, upd_div_s, drop_s, small_s;
  logic               busy_x_s, busy_y_s, done_x_s, done_y_s;
  logic [COORD_W-1:0] quot_x_s, quot_y_s;
  logic [COORD_W-1:0] ball_x_r, ball_y_r;
  logic               ball_found_r, result_valid_r;
  logic [CNT_W-1:0]   pixel_count_r;
  logic [15:0]        frame_err_r;

  assign s_axis_video.tready = m_axis_video.tready;
  assign m_axis_video.tvalid = s_axis_video.tvalid;
  assign m_axis_video.tuser  = s_axis_video.tuser;
  assign m_axis_video.tlast  = s_axis_video.tlast;
  assign m_axis_video.tkeep  = 2'b11;
  assign m_axis_video.tdata  = (overlay_en && mask_s) ? OVERLAY_RGB : s_axis_video.tdata;

  // Per-beat classification, beat coordinates and next accumulator values; an SOF beat restarts at (0,0).
  always_comb begin
    beat_s      = s_axis_video.tvalid && m_axis_video.tready;
    mask_s      = in_window({1'b0, s_axis_video.tdata[R_MSB:R_LSB]}, {1'b0, r_lo}, {1'b0, r_hi})
               && in_window(s_axis_video.tdata[G_MSB:G_LSB], g_lo, g_hi)
               && in_window({1'b0, s_axis_video.tdata[B_MSB:B_LSB]}, {1'b0, b_lo}, {1'b0, b_hi});
    x_beat_s    = s_axis_video.tuser ? '0 : x_r;
    y_beat_s    = s_axis_video.tuser ? '0 : y_r;
    base_sx_s   = s_axis_video.tuser ? '0 : sum_x_r;
    base_sy_s   = s_axis_video.tuser ? '0 : sum_y_r;
    base_cnt_s  = s_axis_video.tuser ? '0 : cnt_r;
    sum_x_nxt_s = base_sx_s + (mask_s ? ACC_W'(x_beat_s) : '0);
    sum_y_nxt_s = base_sy_s + (mask_s ? ACC_W'(y_beat_s) : '0);
    if (mask_s && (base_cnt_s != '1)) begin
      cnt_nxt_s = base_cnt_s + CNT_W'(1);
    end else begin
      cnt_nxt_s = base_cnt_s;
    end
    frame_end_s = beat_s && s_axis_video.tlast && (y_beat_s == Y_MAX);
    sof_err_s   = beat_s && s_axis_video.tuser && active_r;
  end

  // Next-state and control decode for the result FSM.
  always_comb begin
    state_nxt_s = state_r;
    div_start_s = 1'b0;
    upd_div_s   = 1'b0;
    drop_s      = 1'b0;
    small_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_end_s && (cnt_nxt_s >= MIN_CNT)) begin
          div_start_s = 1'b1;
          state_nxt_s = DIV;
        end else if (frame_end_s) begin
          small_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DIV: begin
        drop_s = frame_end_s;
        if (done_x_s && done_y_s) begin
          upd_div_s   = 1'b1;
          state_nxt_s = IDLE;
        end else if (!busy_x_s && !busy_y_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DIV;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge s_axis_video_aclk) begin
    if (!s_axis_video_aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Position counters, frame accumulators and frame-end latching.
  always_ff @(posedge s_axis_video_aclk) begin
    if (!s_axis_video_aresetn) begin
      x_r          <= '0;
      y_r          <= '0;
      sum_x_r      <= '0;
      sum_y_r      <= '0;
      cnt_r        <= '0;
      active_r     <= 1'b0;
      cnt_lat_r    <= '0;
      small_pend_r <= 1'b0;
      frame_err_r  <= 16'd0;
    end else begin
      if (beat_s && frame_end_s) begin
        x_r      <= '0;
        y_r      <= '0;
        sum_x_r  <= '0;
        sum_y_r  <= '0;
        cnt_r    <= '0;
        active_r <= 1'b0;
      end else if (beat_s) begin
        sum_x_r  <= sum_x_nxt_s;
        sum_y_r  <= sum_y_nxt_s;
        cnt_r    <= cnt_nxt_s;
        active_r <= 1'b1;
        if (s_axis_video.tlast) begin
          x_r <= '0;
          y_r <= (y_beat_s == Y_MAX) ? y_beat_s : y_beat_s + COORD_W'(1);
        end else begin
          x_r <= (x_beat_s == X_MAX) ? x_beat_s : x_beat_s + COORD_W'(1);
          y_r <= y_beat_s;
        end
      end
      if (div_start_s || small_s) begin
        cnt_lat_r <= cnt_nxt_s;
      end
      small_pend_r <= small_s;
      frame_err_r  <= frame_err_r + {15'd0, sof_err_s} + {15'd0, drop_s};
    end
  end

  // Result registers, refreshed once per completed frame.
  always_ff @(posedge s_axis_video_aclk) begin
    if (!s_axis_video_aresetn) begin
      ball_x_r       <= '0;
      ball_y_r       <= '0;
      ball_found_r   <= 1'b0;
      pixel_count_r  <= '0;
      result_valid_r <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      if (upd_div_s) begin
        ball_x_r       <= quot_x_s;
        ball_y_r       <= quot_y_s;
        ball_found_r   <= 1'b1;
        pixel_count_r  <= cnt_lat_r;
        result_valid_r <= 1'b1;
      end else if (small_pend_r) begin
        ball_found_r   <= 1'b0;
        pixel_count_r  <= cnt_lat_r;
        result_valid_r <= 1'b1;
      end
    end
  end

  seq_divider #(.DIVIDEND_W(ACC_W), .DIVISOR_W(CNT_W), .QUOT_W(COORD_W)) u_div_x (
    .clk      (s_axis_video_aclk),
    .rst_n    (s_axis_video_aresetn),
    .start    (div_start_s),
    .dividend (sum_x_nxt_s),
    .divisor  (cnt_nxt_s),
    .busy     (busy_x_s),
    .done     (done_x_s),
    .quotient (quot_x_s)
  );

  seq_divider #(.DIVIDEND_W(ACC_W), .DIVISOR_W(CNT_W), .QUOT_W(COORD_W)) u_div_y (
    .clk      (s_axis_video_aclk),
    .rst_n    (s_axis_video_aresetn),
    .start    (div_start_s),
    .dividend (sum_y_nxt_s),
    .divisor  (cnt_nxt_s),
    .busy     (busy_y_s),
    .done     (done_y_s),
    .quotient (quot_y_s)
  );

  assign ball_x        = ball_x_r;
  assign ball_y        = ball_y_r;
  assign ball_found    = ball_found_r;
  assign pixel_count   = pixel_count_r;
  assign result_valid  = result_valid_r;
  assign frame_err_cnt = frame_err_r;

endmodule

// File: tb/tb_axis_ball_centroid.sv
// Scoreboard bench for axis_ball_centroid on an 8x4 image: the driver queues expected
// stream beats and results, a negedge monitor pops and compares them.
module tb_axis_ball_centroid;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        overlay_en = 1'b0;
  logic [4:0]  r_lo, r_hi, b_lo, b_hi;
  logic [5:0]  g_lo, g_hi;
  logic [11:0] ball_x, ball_y;
  logic        ball_found;
  logic [19:0] pixel_count;
  logic        result_valid;
  logic [15:0] frame_err_cnt;

  always #5 clk = ~clk;

  axis_ball_centroid_if s_if ();
  axis_ball_centroid_if m_if ();

  axis_ball_centroid #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .MIN_PIXELS(2)) dut (
    .s_axis_video_aclk    (clk),
    .s_axis_video_aresetn (aresetn),
    .s_axis_video         (s_if),
    .m_axis_video         (m_if),
    .r_lo(r_lo), .r_hi(r_hi), .g_lo(g_lo), .g_hi(g_hi), .b_lo(b_lo), .b_hi(b_hi),
    .overlay_en   (overlay_en),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .ball_found   (ball_found),
    .pixel_count  (pixel_count),
    .result_valid (result_valid),
    .frame_err_cnt(frame_err_cnt)
  );

  typedef struct {
    logic [15:0] data;
    logic        user;
    logic        last;
    logic        rdy;
  } beat_t;

  typedef struct {
    int          at;
    logic        found;
    logic [19:0] cnt;
    logic [11:0] x;
    logic [11:0] y;
  } res_t;

  beat_t sq[$];
  res_t  rq[$];
  int    ncnt  = 0;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (negedge %0d)", name, act, exp, ncnt);
    end
  endtask

  function automatic logic [31:0] px(input int x, input int y);
    return 32'd1 << (y * 8 + x);
  endfunction

  function automatic logic [15:0] exp_out(input logic [15:0] d);
    return (overlay_en && d == 16'hFFFF) ? 16'hF800 : d;
  endfunction

  // Monitor: compares every presented output beat and every result pulse against the queues.
  always @(negedge clk) begin
    beat_t b;
    res_t  r;
    ncnt = ncnt + 1;
    if (m_if.tvalid) begin
      if (sq.size() == 0) begin
        tests++; fails++;
        $display("FAIL stream_extra: got tdata %0h, expected no beat", m_if.tdata);
      end else begin
        b = sq.pop_front();
        chk("m_tdata", {16'd0, m_if.tdata}, {16'd0, b.data});
        chk("m_tuser", {31'd0, m_if.tuser}, {31'd0, b.user});
        chk("m_tlast", {31'd0, m_if.tlast}, {31'd0, b.last});
        chk("s_tready", {31'd0, s_if.tready}, {31'd0, b.rdy});
      end
    end
    if (result_valid) begin
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL result_unexpected: got result_valid=1, expected 0 (negedge %0d)", ncnt);
      end else begin
        r = rq.pop_front();
        chk("res_time", ncnt, r.at);
        chk("ball_found", {31'd0, ball_found}, {31'd0, r.found});
        chk("pixel_count", {12'd0, pixel_count}, {12'd0, r.cnt});
        chk("ball_x", {20'd0, ball_x}, {20'd0, r.x});
        chk("ball_y", {20'd0, ball_y}, {20'd0, r.y});
      end
    end else if (rq.size() > 0 && ncnt > rq[0].at) begin
      r = rq.pop_front();
      tests++; fails++;
      $display("FAIL result_missing: got no result_valid, expected at negedge %0d", r.at);
    end
  end

  task automatic drive_beat(input logic [15:0] d, input logic u, input logic l, input int nstall, output int k);
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < nstall; i++) begin
      m_if.tready = 1'b0;
      sq.push_back('{exp_out(d), u, l, 1'b0});
      @(posedge clk); #1;
    end
    m_if.tready = 1'b1;
    sq.push_back('{exp_out(d), u, l, 1'b1});
    k = ncnt + 1;
    @(posedge clk); #1;
  endtask

  // Sends nlines of an 8-wide frame: white where the map bit is set, 16'hFFFE (blue one below window)
  // on the x+y==3 diagonal, a ramp elsewhere. exp_div selects the 13-edge or 1-edge result latency.
  task automatic send_frame(input logic [31:0] white, input int nlines, input int stall_idx, input int nstall,
                            input bit exp_res, input bit exp_div, input logic [19:0] cnt,
                            input logic [11:0] ex, input logic [11:0] ey);
    logic [15:0] d;
    int k;
    for (int yy = 0; yy < nlines; yy++) begin
      for (int xx = 0; xx < 8; xx++) begin
        if (white[yy * 8 + xx]) d = 16'hFFFF;
        else if (xx + yy == 3) d = 16'hFFFE;
        else d = 16'(16'h0841 * (xx + yy));
        drive_beat(d, (xx == 0 && yy == 0), (xx == 7), (yy * 8 + xx == stall_idx) ? nstall : 0, k);
        if (exp_res && yy == 3 && xx == 7) begin
          rq.push_back('{exp_div ? k + 14 : k + 2, exp_div, cnt, ex, ey});
        end
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    s_if.tdata  = 16'd0;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tkeep  = 2'b11;
    m_if.tready = 1'b1;
    r_lo = 5'd31; r_hi = 5'd31;
    g_lo = 6'd63; g_hi = 6'd63;
    b_lo = 5'd31; b_hi = 5'd31;

    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_ball_x", {20'd0, ball_x}, 32'd0);
    chk("rst_ball_y", {20'd0, ball_y}, 32'd0);
    chk("rst_found", {31'd0, ball_found}, 32'd0);
    chk("rst_count", {12'd0, pixel_count}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_err", {16'd0, frame_err_cnt}, 32'd0);
    chk("tkeep", {30'd0, m_if.tkeep}, 32'd3);

    // (2,1)+(4,3): centroid (3,2) through the dividers
    send_frame(px(2,1) | px(4,3), 4, -1, 0, 1'b1, 1'b1, 20'd2, 12'd3, 12'd2);
    idle(20);
    // single ball pixel: below MIN_PIXELS, coordinates hold
    send_frame(px(5,2), 4, -1, 0, 1'b1, 1'b0, 20'd1, 12'd3, 12'd2);
    idle(5);
    // five-cycle output stall on the (2,1) white pixel: counted once
    send_frame(px(2,1) | px(4,3), 4, 10, 5, 1'b1, 1'b1, 20'd2, 12'd3, 12'd2);
    idle(20);
    // overlay on; SOF pixel and final beat both counted: sums 10,5 over 3
    overlay_en = 1'b1;
    send_frame(px(0,0) | px(7,3) | px(3,2), 4, -1, 0, 1'b1, 1'b1, 20'd3, 12'd3, 12'd1);
    idle(20);
    overlay_en = 1'b0;
    // truncated frame, then a full frame whose partial predecessor must be discarded
    send_frame(px(1,0), 2, -1, 0, 1'b0, 1'b0, 20'd0, 12'd0, 12'd0);
    send_frame(px(6,1) | px(6,3), 4, -1, 0, 1'b1, 1'b1, 20'd2, 12'd6, 12'd2);
    idle(20);
    chk("frame_err_cnt", {16'd0, frame_err_cnt}, 32'd1);
    // reset four cycles into the division: no result, everything cleared
    send_frame(px(2,1) | px(4,3), 4, -1, 0, 1'b0, 1'b0, 20'd0, 12'd0, 12'd0);
    repeat (4) @(posedge clk);
    #1 aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    chk("div_rst_ball_x", {20'd0, ball_x}, 32'd0);
    chk("div_rst_ball_y", {20'd0, ball_y}, 32'd0);
    chk("div_rst_found", {31'd0, ball_found}, 32'd0);
    chk("div_rst_count", {12'd0, pixel_count}, 32'd0);
    chk("div_rst_err", {16'd0, frame_err_cnt}, 32'd0);
    idle(20);
    // sums 9,5 over 3: truncated quotients (3,1)
    send_frame(px(1,1) | px(3,1) | px(5,3), 4, -1, 0, 1'b1, 1'b1, 20'd3, 12'd3, 12'd1);
    idle(20);
    chk("queues_drained", sq.size() + rq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
